// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for alu_seq_ctrl: opcodes, FSM states, CCR bit layout.
// Defining ALU_SEQ_CMP_EN makes opcode 8 a compare (SUB that updates flags only).
package alu_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_LSL = 4'd2,
    OP_LSR = 4'd3,
    OP_XOR = 4'd4,
    OP_COM = 4'd5,
    OP_NEG = 4'd6,
    OP_CLR = 4'd7,
    OP_CMP = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPERAND,
    S_EXECUTE,
    S_WRITEBACK
  } state_e;

  localparam int unsigned CCR_N = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_Z = 0;

  // Opcode retires with done (flags/result updated) rather than err.
  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_CMP_EN
    return (op <= OP_CLR) || (op == OP_CMP);
`else
    return op <= OP_CLR;
`endif
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return op <= OP_CLR;
  endfunction

  function automatic logic [3:0] alu_func(input logic [3:0] op);
`ifdef ALU_SEQ_CMP_EN
    if (op == OP_CMP) return OP_SUB;
`endif
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_regfile.sv
// Register file for alu_seq_ctrl: NREG x DW, one synchronous write port,
// combinational read ports for operand A, operand B and debug.
module seq_regfile #(
  parameter int unsigned NREG = 4,
  parameter int unsigned DW   = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [$clog2(NREG)-1:0] ra_addr_i,
  output logic [DW-1:0]           ra_data_o,
  input  logic [$clog2(NREG)-1:0] rb_addr_i,
  output logic [DW-1:0]           rb_data_o,
  input  logic [$clog2(NREG)-1:0] dbg_addr_i,
  output logic [DW-1:0]           dbg_data_o
);

  logic [DW-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 8-bit ALU: accept, fetch operands, execute,
// write back. Optional CMP opcode is enabled with `define ALU_SEQ_CMP_EN.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned DW   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_op,
  input  logic [$clog2(NREG)-1:0] req_rd,
  input  logic [$clog2(NREG)-1:0] req_rs,
  input  logic                    req_use_imm,
  input  logic [DW-1:0]           req_imm,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic [3:0]              alu_f,
  input  logic [DW-1:0]           alu_y,
  input  logic                    alu_n,
  input  logic                    alu_v,
  input  logic                    alu_z,
  output logic                    done,
  output logic                    err,
  output logic [DW-1:0]           result,
  output logic [2:0]              ccr,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [DW-1:0]           dbg_data
);

  state_e                  state_q;
  logic [3:0]              op_q;
  logic [$clog2(NREG)-1:0] rd_q, rs_q;
  logic                    use_imm_q;
  logic [DW-1:0]           imm_q;
  logic [DW-1:0]           alu_a_q, alu_b_q, y_q, result_q;
  logic [3:0]              alu_f_q, alu_f_d;
  logic                    n_q, v_q, z_q;
  logic                    done_q, err_q;
  logic [2:0]              ccr_q;
  logic [DW-1:0]           ra_data, rb_data;
  logic                    legal_d, wb_we_d;

  always_comb begin
    legal_d = op_legal(op_q);
    alu_f_d = alu_func(op_q);
    wb_we_d = (state_q == S_WRITEBACK) && legal_d && op_writes_reg(op_q);
  end

  seq_regfile #(
    .NREG(NREG),
    .DW  (DW)
  ) u_regfile (
    .clk_i     (clk),
    .reset_i   (reset),
    .we_i      (wb_we_d),
    .waddr_i   (rd_q),
    .wdata_i   (y_q),
    .ra_addr_i (rd_q),
    .ra_data_o (ra_data),
    .rb_addr_i (rs_q),
    .rb_data_o (rb_data),
    .dbg_addr_i(dbg_sel),
    .dbg_data_o(dbg_data)
  );

  // done/err are raised on entry to WRITEBACK so they are high during that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_f_q   <= OP_CLR;
      y_q       <= '0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      ccr_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            rd_q      <= req_rd;
            rs_q      <= req_rs;
            use_imm_q <= req_use_imm;
            imm_q     <= req_imm;
            state_q   <= S_OPERAND;
          end
        end
        S_OPERAND: begin
          alu_a_q <= ra_data;
          alu_b_q <= use_imm_q ? imm_q : rb_data;
          alu_f_q <= alu_f_d;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          y_q     <= alu_y;
          n_q     <= alu_n;
          v_q     <= alu_v;
          z_q     <= alu_z;
          done_q  <= legal_d;
          err_q   <= ~legal_d;
          state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (legal_d) begin
            result_q     <= y_q;
            ccr_q[CCR_N] <= n_q;
            ccr_q[CCR_V] <= v_q;
            ccr_q[CCR_Z] <= z_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign ccr       = ccr_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural ALU attached and a reference model
// of the controller's externally visible behaviour.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0;
  logic [1:0] req_rd = '0;
  logic [1:0] req_rs = '0;
  logic       req_use_imm = 1'b0;
  logic [7:0] req_imm = '0;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_f;
  logic       alu_n, alu_v, alu_z;
  logic       done, err;
  logic [7:0] result;
  logic [2:0] ccr;
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  alu_seq_ctrl #(.NREG(4), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_use_imm(req_use_imm), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
    .done(done), .err(err), .result(result), .ccr(ccr),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // The attached ALU, bit-level; undefined functions produce junk that must be discarded.
  always_comb begin
    alu_y = '0;
    alu_v = 1'b0;
    case (alu_f)
      4'd0: begin alu_y = alu_a + alu_b; alu_v = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]); end
      4'd1: begin alu_y = alu_a - alu_b; alu_v = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]); end
      4'd2: alu_y = {alu_a[6:0], 1'b0};
      4'd3: alu_y = {1'b0, alu_a[7:1]};
      4'd4: alu_y = alu_a ^ alu_b;
      4'd5: alu_y = ~alu_a;
      4'd6: begin alu_y = 8'd0 - alu_a; alu_v = (alu_a == 8'h80); end
      4'd7: alu_y = '0;
      default: alu_y = alu_a ^ 8'h5A;
    endcase
    alu_n = alu_y[7];
    alu_z = (alu_y == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic on integers: signed range test for overflow.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output logic [7:0] y, output logic [2:0] nvz);
    int sa, sb, r;
    logic v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    v = 1'b0;
    r = 0;
    case (op)
      0: begin r = sa + sb; v = (r > 127) || (r < -128); end
      1: begin r = sa - sb; v = (r > 127) || (r < -128); end
      2: r = (a * 2) % 256;
      3: r = a / 2;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = -sa; v = (r > 127); end
      default: r = 0;
    endcase
    y = r[7:0];
    nvz = {(y >= 8'd128), v, (y == 8'd0)};
  endfunction

  logic [7:0] m_R [4];
  logic [7:0] m_result, m_y, m_a, m_b;
  logic [3:0] m_f;
  logic [2:0] m_ccr, m_flags;
  logic [1:0] m_rd;
  logic       m_done, m_err, m_legal, m_wr, m_on = 1'b0;
  int unsigned m_busy;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) m_R[i] = 8'h00;
      m_ccr = 3'b000; m_result = 8'h00; m_done = 1'b0; m_err = 1'b0;
      m_busy = 0; m_on = 1'b1;
    end else if (m_on) begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_busy == 3) begin
        if (m_legal) begin
          m_result = m_y;
          m_ccr = m_flags;
          if (m_wr) m_R[m_rd] = m_y;
        end
        m_busy = 0;
      end else if (m_busy != 0) begin
        m_busy++;
        if (m_busy == 3) begin m_done = m_legal; m_err = !m_legal; end
      end else if (req_valid) begin
`ifdef ALU_SEQ_CMP_EN
        m_legal = (req_op <= 4'd8);
`else
        m_legal = (req_op <= 4'd7);
`endif
        m_wr = (req_op <= 4'd7);
        m_f  = (req_op == 4'd8 && m_legal) ? 4'd1 : req_op;
        m_rd = req_rd;
        m_a  = m_R[req_rd];
        m_b  = req_use_imm ? req_imm : m_R[req_rs];
        ref_alu(int'(m_f), int'(m_a), int'(m_b), m_y, m_flags);
        m_busy = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("ready", req_ready, (m_busy == 0));
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("result", result, m_result);
      chk("ccr", ccr, m_ccr);
      chk("dbg_data", dbg_data, m_R[dbg_sel]);
      if (m_busy >= 2) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_f", alu_f, m_f);
      end
    end
  end

  // Entered at posedge+1 while idle; returns at posedge+1 once the result is committed.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic ui, input logic [7:0] imm,
                       output logic got_done, output logic got_err);
    int unsigned lat, low;
    got_done = 1'b0; got_err = 1'b0; lat = 0; low = 0;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs; req_use_imm = ui; req_imm = imm;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_rd = 2'($urandom); req_rs = 2'($urandom);
    req_use_imm = 1'($urandom); req_imm = 8'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!req_ready) low++;
      if (done || err) begin lat = k; got_done = done; got_err = err; break; end
      @(posedge clk); #1;
      dbg_sel = 2'($urandom_range(0, 3));
      req_valid = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (!req_ready) low++;
    chk("latency", lat, 3);
    chk("ready_low_cycles", low, 3);
    @(posedge clk); #1;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    dbg_sel = idx;
    #1;
    chk(name, dbg_data, exp);
  endtask

  logic d, e;
  int unsigned acc [2];
  int unsigned n_acc, seen_done;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_alu_f", alu_f, 4'd7);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_ready", req_ready, 1'b1);

    issue(4'd7, 2'd0, 2'd0, 1'b0, 8'h00, d, e);
    chk("clr_ccr", ccr, 3'b001);
    issue(4'd0, 2'd0, 2'd0, 1'b1, 8'h70, d, e);
    issue(4'd0, 2'd0, 2'd0, 1'b1, 8'h20, d, e);
    chk("add_done", d, 1'b1);
    chk_reg("add_r0", 2'd0, 8'h90);
    chk("add_ccr", ccr, 3'b110);
    chk("add_result", result, 8'h90);

    issue(4'd7, 2'd1, 2'd0, 1'b0, 8'h00, d, e);
    issue(4'd0, 2'd1, 2'd0, 1'b1, 8'h05, d, e);
    issue(4'd1, 2'd1, 2'd0, 1'b1, 8'h05, d, e);
    chk_reg("sub_r1", 2'd1, 8'h00);
    chk("sub_ccr", ccr, 3'b001);

    issue(4'd7, 2'd2, 2'd0, 1'b0, 8'h00, d, e);
    issue(4'd0, 2'd2, 2'd0, 1'b1, 8'h80, d, e);
    issue(4'd6, 2'd2, 2'd3, 1'b0, 8'h00, d, e);
    chk_reg("neg_r2", 2'd2, 8'h80);
    chk("neg_ccr", ccr, 3'b110);
    issue(4'd5, 2'd2, 2'd0, 1'b1, 8'hFF, d, e);
    chk_reg("com_r2", 2'd2, 8'h7F);
    chk("com_ccr", ccr, 3'b000);

    issue(4'd7, 2'd3, 2'd0, 1'b0, 8'h00, d, e);
    issue(4'd0, 2'd3, 2'd0, 1'b1, 8'h11, d, e);
    issue(4'hC, 2'd3, 2'd0, 1'b1, 8'h22, d, e);
    chk("ill_err", e, 1'b1);
    chk("ill_done", d, 1'b0);
    chk_reg("ill_r3", 2'd3, 8'h11);
    chk("ill_ccr", ccr, 3'b000);
    chk("ill_result", result, 8'h11);
    issue(4'd8, 2'd3, 2'd0, 1'b1, 8'h11, d, e);
    chk_reg("op8_r3", 2'd3, 8'h11);
`ifdef ALU_SEQ_CMP_EN
    chk("cmp_done", d, 1'b1);
    chk("cmp_ccr", ccr, 3'b001);
    chk("cmp_result", result, 8'h00);
`else
    chk("op8_err", e, 1'b1);
    chk("op8_ccr", ccr, 3'b000);
`endif

    // Back-to-back with req_valid held high.
    req_valid = 1'b1; req_op = 4'd0; req_rd = 2'd0; req_rs = 2'd1; req_use_imm = 1'b1; req_imm = 8'h01;
    n_acc = 0; seen_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (req_ready) begin acc[n_acc] = i; n_acc++; end
      if (n_acc == 2) break;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_spacing", acc[1] - acc[0], 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin seen_done = 1; break; end
    end
    chk("b2b_done_seen", seen_done, 1);
    @(posedge clk); #1;
    chk_reg("b2b_r0", 2'd0, 8'h92);

    // Reset while the operation is in EXECUTE.
    req_valid = 1'b1; req_op = 4'd0; req_rd = 2'd1; req_use_imm = 1'b1; req_imm = 8'h01;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_ready", req_ready, 1'b1);
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("rstmid_no_done", seen_done, 0);
    @(posedge clk); #1;
    chk("rstmid_ready2", req_ready, 1'b1);
    chk_reg("rstmid_r1", 2'd1, 8'h00);
    chk("rstmid_ccr", ccr, 3'b000);

    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      issue(op, 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), d, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller for the 8-bit signed ALU (A, B, F in; Y, N, V, Z out).
- Accepts one operation request at a time over a valid/ready handshake and reads operands from an internal 4x8 register file (or an immediate).
- Drives the ALU inputs from registers, captures the result and flags, writes back the result, and maintains a condition-code register (CCR).
- Sits between the instruction decode stage and the combinational ALU.

Parameters:
- NREG, 4, number of register-file entries (index width = clog2(NREG) = 2)
- DW, 8, datapath width; must match the ALU

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (high only in IDLE)
- req_op  input  4  ALU function: 0 ADD, 1 SUB, 2 LSL, 3 LSR, 4 XOR, 5 COM, 6 NEG, 7 CLR
- req_rd  input  2  destination register, also source of operand A
- req_rs  input  2  source register for operand B
- req_use_imm  input  1  1 = operand B from req_imm
- req_imm  input  8  immediate operand B
- alu_a  output  8  registered ALU operand A
- alu_b  output  8  registered ALU operand B
- alu_f  output  4  registered ALU function select
- alu_y  input  8  ALU result
- alu_n, alu_v, alu_z  input  1 each  ALU flags
- done  output  1  one-cycle pulse, operation retired
- err  output  1  one-cycle pulse, illegal opcode retired
- result  output  8  last retired result, held until next retire
- ccr  output  3  {N,V,Z}
- dbg_sel  input  2  register-file debug read select
- dbg_data  output  8  R[dbg_sel], combinational read

Behaviour:
- All state changes on the clk rising edge.
- reset (synchronous, any state, including mid-operation):
  - state = IDLE; in-flight operation is discarded with no writeback.
  - R[0..3] = 0, ccr = 0, result = 0, alu_a = 0, alu_b = 0, alu_f = 7.
  - done = 0, err = 0.
- FSM (four states):
  - IDLE: req_ready = 1. When req_valid is high, latch op, rd, rs, use_imm, imm → OPERAND.
  - OPERAND: alu_a <= R[rd]; alu_b <= use_imm ? imm : R[rs]; alu_f <= op → EXECUTE.
  - EXECUTE: capture alu_y, alu_n, alu_v, alu_z into internal registers → WRITEBACK.
  - WRITEBACK: if op ≤ 7, then R[rd] <= captured Y; ccr <= {N,V,Z}; result <= Y; done = 1. Else err = 1, with no R or ccr change (result is also left unchanged). → IDLE.
- Latency and throughput:
  - Accept at cycle T; done pulses in cycle T+3.
  - req_ready is low in T+1..T+3, so throughput is one operation per 4 cycles.
- Register dependency: an operation accepted in the IDLE cycle after WRITEBACK reads the updated register. No forwarding is needed.
- req_valid is ignored outside IDLE; request fields need only be stable in the accept cycle.
- Illegal op (8–15 without the optional feature): the ALU is still driven with F = op, but its output is discarded.
- Unary ops (LSL, LSR, COM, NEG, CLR): alu_b is still driven per use_imm/rs; the ALU ignores it.
- CLR writes 0 and sets ccr = {0,0,1}.
- V is taken from the ALU for every op; the ALU clears it for non-arithmetic ops.
- dbg_data reflects a write starting the cycle after WRITEBACK.

Optional Feature:
- Macro: ALU_SEQ_CMP_EN.
- Defined: opcode 8 = CMP. Drive alu_f = 1 (SUB); in WRITEBACK, update ccr and result, pulse done, skip the register write.
- Undefined: opcode 8 is illegal (err pulse, nothing updated).

Decomposition:
- Shared header alu_defs.vh holds:
  - Opcode constants OP_ADD..OP_CLR and OP_CMP.
  - State encodings S_IDLE, S_OPERAND, S_EXECUTE, S_WRITEBACK.
  - CCR bit indices CCR_N = 2, CCR_V = 1, CCR_Z = 0.
- One natural sub-module, seq_regfile: NREG x DW, one synchronous write port and three combinational read ports (A, B, debug). All reset to 0.
- The bench instantiates alu_seq_ctrl with the real ALU attached.

Test Plan:
- Reset, then ADD R0=0x70 (loaded via CLR then ADD imm 0x70), ADD imm 0x20 → R0 = 0x90, ccr = {1,1,0}, done at accept+3.
- SUB R1=0x05, imm 0x05 → R1 = 0x00, ccr = {0,0,1}; req_ready low for exactly 3 cycles.
- NEG R2=0x80 → R2 = 0x80, ccr = {1,1,0}; then COM R2 → 0x7F, ccr = {0,0,0}.
- Opcode 0xC with R3 = 0x11 → err pulse, done = 0, R3 = 0x11, ccr unchanged. With ALU_SEQ_CMP_EN, opcode 8 on R3 vs imm 0x11 → ccr Z = 1, R3 unchanged.
- Back-to-back: ADD R0 += 1 issued twice in a row with req_valid held high → second accept in the IDLE cycle after the first done; R0 ends at +2.
- Assert reset during EXECUTE of ADD R1 imm 0x01 → no done, R1 = 0, ccr = 0, req_ready = 1 the cycle after reset deasserts.
